// File: rtl/component_serializer.sv
// Parallel-in / serial-out unroller: captures CYCLES+1 words in one handshake and
// streams them out highest index first on a valid/ready interface.
module component_serializer #(
    parameter int WIDTH  = 8,
    parameter int CYCLES = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load_valid,
    output logic                         load_ready,
    input  logic [CYCLES:0][WIDTH-1:0]   data_all_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             data_out,
    output logic                         out_last,
    output logic                         busy
);

    localparam int IW = $clog2(CYCLES + 1);
    localparam logic [IW-1:0] IDX_TOP = IW'(CYCLES);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t                        state_q, state_d;
    logic [IW-1:0]                 idx_q, idx_d;
    logic [CYCLES:0][WIDTH-1:0]    buf_q, buf_d;
    logic                          load_xfer_s;
    logic                          out_xfer_s;

    // Output decode from registered state; load_ready also looks at out_ready
    // so a new vector can be taken in the same cycle the last word leaves.
    always_comb begin
        out_valid  = 1'b0;
        busy       = 1'b0;
        data_out   = {WIDTH{1'b0}};
        out_last   = 1'b0;
        load_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                load_ready = 1'b1;
            end
            ST_SHIFT: begin
                out_valid  = 1'b1;
                busy       = 1'b1;
                data_out   = buf_q[idx_q];
                out_last   = (idx_q == {IW{1'b0}});
                load_ready = (idx_q == {IW{1'b0}}) && out_ready;
            end
            default: begin
                load_ready = 1'b0;
            end
        endcase
        load_xfer_s = load_valid && load_ready;
        out_xfer_s  = out_valid && out_ready;
    end

    // Next-state logic: everything holds unless a handshake moves it.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        case (state_q)
            ST_IDLE: begin
                if (load_xfer_s) begin
                    buf_d   = data_all_in;
                    idx_d   = IDX_TOP;
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (out_xfer_s) begin
                    if (idx_q == {IW{1'b0}}) begin
                        if (load_xfer_s) begin
                            buf_d   = data_all_in;
                            idx_d   = IDX_TOP;
                            state_d = ST_SHIFT;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        idx_d = idx_q - {{(IW-1){1'b0}}, 1'b1};
                    end
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = {IW{1'b0}};
            end
        endcase
    end

    // State, index and word buffer registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            idx_q   <= {IW{1'b0}};
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
        end
    end

endmodule

// File: tb/tb_component_serializer.sv
// Randomized self-checking bench for component_serializer against a queue-based
// model of the word stream, plus a loopback tap-line reconstruction check.
module tb_component_serializer;

    localparam int WIDTH  = 8;
    localparam int CYCLES = 4;

    logic                        clk;
    logic                        rst;
    logic                        load_valid;
    logic                        load_ready;
    logic [CYCLES:0][WIDTH-1:0]  data_all_in;
    logic                        out_valid;
    logic                        out_ready;
    logic [WIDTH-1:0]            data_out;
    logic                        out_last;
    logic                        busy;

    component_serializer #(.WIDTH(WIDTH), .CYCLES(CYCLES)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .data_all_in(data_all_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .data_out   (data_out),
        .out_last   (out_last),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // model: words still to be emitted, oldest first
    logic [WIDTH-1:0]            mq[$];
    logic [CYCLES:0][WIDTH-1:0]  cur_vec;
    logic [WIDTH-1:0]            hist [1:CYCLES];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [CYCLES:0][WIDTH-1:0] rand_vec();
        logic [CYCLES:0][WIDTH-1:0] v;
        for (int i = 0; i <= CYCLES; i++) v[i] = WIDTH'($urandom);
        return v;
    endfunction

    // One clock cycle: drive inputs, check outputs against model, advance model.
    task automatic cycle(input logic r, input logic lv,
                         input logic [CYCLES:0][WIDTH-1:0] v, input logic ordy);
        logic             e_valid, e_last, e_lr, ox, lx;
        logic [WIDTH-1:0] e_data, seen;
        rst = r; load_valid = lv; data_all_in = v; out_ready = ordy;
        #2;
        e_valid = (mq.size() > 0);
        e_data  = e_valid ? mq[0] : 8'd0;
        e_last  = (mq.size() == 1);
        e_lr    = (mq.size() == 0) || ((mq.size() == 1) && ordy);
        check("out_valid",  32'(out_valid),  32'(e_valid));
        check("busy",       32'(busy),       32'(e_valid));
        check("data_out",   32'(data_out),   32'(e_data));
        check("out_last",   32'(out_last),   32'(e_last));
        check("load_ready", 32'(load_ready), 32'(e_lr));
        seen = data_out;
        if (r && e_valid && ordy && e_last) begin
            check("loop0", 32'(seen), 32'(cur_vec[0]));
            for (int i = 1; i <= CYCLES; i++) check("loop_tap", 32'(hist[i]), 32'(cur_vec[i]));
        end
        @(posedge clk);
        if (!r) begin
            mq.delete();
            for (int i = 1; i <= CYCLES; i++) hist[i] = 8'd0;
        end else begin
            ox = e_valid && ordy;
            lx = lv && e_lr;
            if (ox) begin
                for (int i = CYCLES; i >= 2; i--) hist[i] = hist[i-1];
                hist[1] = seen;
                void'(mq.pop_front());
            end
            if (lx) begin
                for (int i = CYCLES; i >= 0; i--) mq.push_back(v[i]);
                cur_vec = v;
            end
        end
        @(negedge clk);
    endtask

    logic [CYCLES:0][WIDTH-1:0] va, vb, vz;

    initial begin
        va = {8'd14, 8'd13, 8'd12, 8'd11, 8'd10};
        vb = {8'd24, 8'd23, 8'd22, 8'd21, 8'd20};
        vz = '0;
        cur_vec = '0;
        for (int i = 1; i <= CYCLES; i++) hist[i] = 8'd0;
        rst = 1'b0; load_valid = 1'b0; out_ready = 1'b0; data_all_in = '0;
        @(posedge clk);
        @(negedge clk);
        mq.delete();

        // reset held with random inputs
        for (int i = 0; i < 2; i++)
            cycle(1'b0, 1'($urandom), rand_vec(), 1'($urandom));
        cycle(1'b1, 1'b0, vz, 1'b0);

        // basic stream
        cycle(1'b1, 1'b1, va, 1'b1);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, vz, 1'b1);

        // stall while 12 is presented
        cycle(1'b1, 1'b1, va, 1'b1);
        for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0, vz, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, vz, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, vz, 1'b1);

        // back-to-back: B offered while A drains
        cycle(1'b1, 1'b1, va, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, vb, 1'b1);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, vz, 1'b1);

        // reset mid-stream then fresh load
        cycle(1'b1, 1'b1, va, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, vz, 1'b1);
        cycle(1'b0, 1'b0, vz, 1'b1);
        cycle(1'b1, 1'b1, va, 1'b1);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, vz, 1'b1);

        // random traffic
        for (int i = 0; i < 600; i++)
            cycle(1'($urandom_range(0, 99) != 0), 1'($urandom), rand_vec(),
                  1'($urandom_range(0, 3) != 0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
